cmd_issue_queue: RTL and testbench

Host-side command front-end placed directly upstream of the four-rank package controller. It buffers host requests in a FIFO and issues them one at a time on the package's `command`/`write_data`/`valid` bus. It holds the issued command stable so the package's rank mux keeps steering the right rank's read path. It returns read data to the host through a one-entry response register with a valid/ready handshake.

---
 rtl/cmd_issue_queue.sv | 179 +++++++++++++++++
 tb/tb_cmd_issue_queue.sv | 592 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_queue.sv
// Host command front-end: FIFO-buffered requests issued one at a time to the package, reads answered via a 1-entry response register.
// Latency: request accepted at edge T shows in fifo_count at T+1 and is issued (valid) at T+2; read response appears the cycle after read_data_valid.
// Backpressure: req_ready drops only when the FIFO is full; a read at the head waits while a response is still pending on rsp_valid/rsp_ready.
//
// Ports:
//   clk, power_on_rst_n             clock, async active-low reset
//   req_valid/req_ready/req_cmd/req_wdata   host request handshake ([33:32] rank, [31] 1=read)
//   rsp_valid/rsp_ready/rsp_rdata/rsp_rank  host read response handshake
//   timeout_err                     one-cycle pulse when a read gets no data in time
//   fifo_count                      current FIFO occupancy
//   command/write_data/valid        issue bus to the package (command/write_data held between issues)
//   read_data/read_data_valid       read return from the package
module cmd_issue_queue #(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 8,
  parameter int WR_GAP     = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     power_on_rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [33:0]              req_cmd,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_rank,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [33:0]              command,
  output logic [DATA_W-1:0]        write_data,
  output logic                     valid,
  input  logic [DATA_W-1:0]        read_data,
  input  logic                     read_data_valid
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int MAX_WAIT = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
  localparam int TMR_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WR, S_WAIT_RD} state_e;

  // Request FIFO storage
  logic [33:0]       cmd_mem_q  [DEPTH];
  logic [DATA_W-1:0] wdat_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop, fifo_empty;
  logic [33:0]       head_cmd;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              load_issue, rsp_load, timeout_d;

  logic [33:0]       command_q;
  logic [DATA_W-1:0] write_data_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_rank_q;
  logic              timeout_q;

  // No pass-through: a full FIFO refuses even when the head pops this cycle.
  assign req_ready  = (count_q < CNT_W'(DEPTH));
  assign push       = req_valid & req_ready;
  assign fifo_empty = (count_q == '0);
  assign head_cmd   = cmd_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem_q[wr_ptr_q]  <= req_cmd;
      wdat_mem_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // FSM next-state and control strobes. tmr counts 1..N inside the wait states.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    load_issue = 1'b0;
    pop        = 1'b0;
    rsp_load   = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A read may only go out when the response register is free.
        if (!fifo_empty && (!head_cmd[31] || !rsp_valid_q)) begin
          state_d    = S_ISSUE;
          load_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        pop     = 1'b1;
        tmr_d   = TMR_W'(1);
        state_d = command_q[31] ? S_WAIT_RD : S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (tmr_q == TMR_W'(WR_GAP)) state_d = S_IDLE;
        else                         tmr_d   = tmr_q + TMR_W'(1);
      end
      S_WAIT_RD: begin
        if (read_data_valid) begin
          rsp_load = 1'b1;
          state_d  = S_IDLE;
        end else if (tmr_q == TMR_W'(RD_TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_valid_d = rsp_load | (rsp_valid_q & ~rsp_ready);

  // Issue bus and response register. command stays put after the issue so the
  // package keeps its rank mux pointed at the rank being read.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      command_q    <= '0;
      write_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_rank_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (load_issue) begin
        command_q    <= head_cmd;
        write_data_q <= wdat_mem_q[rd_ptr_q];
      end
      if (rsp_load) begin
        rsp_rdata_q <= read_data;
        rsp_rank_q  <= command_q[33:32];
      end
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign valid       = (state_q == S_ISSUE);
  assign command     = command_q;
  assign write_data  = write_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_rank    = rsp_rank_q;
  assign timeout_err = timeout_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_cmd_issue_queue.sv
module tb_cmd_issue_queue;
  localparam int DW         = 128;
  localparam int DEPTH      = 8;
  localparam int WR_GAP     = 4;
  localparam int RD_TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           power_on_rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [33:0]    req_cmd;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_rdata;
  logic [1:0]     rsp_rank;
  logic           timeout_err;
  logic [3:0]     fifo_count;
  logic [33:0]    command;
  logic [DW-1:0]  write_data;
  logic           valid;
  logic [DW-1:0]  read_data;
  logic           read_data_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [33:0]   cmd;
    logic [DW-1:0] wd;
  } req_t;

  req_t model_q[$];

  cmd_issue_queue #(
    .DATA_W(DW), .DEPTH(DEPTH), .WR_GAP(WR_GAP), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .power_on_rst_n(power_on_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_rank(rsp_rank),
    .timeout_err(timeout_err), .fifo_count(fifo_count),
    .command(command), .write_data(write_data), .valid(valid),
    .read_data(read_data), .read_data_valid(read_data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed and inputs driven 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_wd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [33:0] mk_cmd(input logic [1:0] rank, input logic rd);
    logic [30:0] low;
    low = 31'($urandom);
    return {rank, rd, low};
  endfunction

  task automatic push(input logic [33:0] c, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_cmd   = c;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  // Returns with the current cycle being the one where valid is high (checks current cycle first).
  task automatic wait_valid(input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    ok = (valid === 1'b1);
  endtask

  task automatic test_reset();
    bit ok;
    bit bad;
    logic [33:0] rc;
    logic [33:0] wc;
    power_on_rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, timeout_err, valid, fifo_count, rsp_rank} !== {1'b1, 9'd0}) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {req_ready, rsp_valid, timeout_err, valid, fifo_count, rsp_rank}, {1'b1, 9'd0});
    end
    checks++;
    if ({command, write_data, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data got cmd=%h wd=%h rd=%h exp=0", command, write_data, rsp_rdata);
    end
    repeat (2) step();
    power_on_rst_n = 1'b1;
    step();
    checks++;
    if ({req_ready, valid, fifo_count} !== {1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=%b", {req_ready, valid, fifo_count}, {1'b1, 1'b0, 4'd0});
    end
    // Reset in the middle of a read with a write still queued.
    rc = mk_cmd(2'd2, 1'b1);
    wc = mk_cmd(2'd3, 1'b0);
    push(rc, rand_wd());
    push(wc, rand_wd());
    wait_valid(4, ok);
    checks++;
    if (!ok || command !== rc) begin
      failures++;
      $display("FAIL reset_pre_issue got valid=%b cmd=%h exp valid=1 cmd=%h", valid, command, rc);
    end
    repeat (3) step();
    checks++;
    if (fifo_count !== 4'd1) begin
      failures++;
      $display("FAIL reset_pre_count got=%0d exp=1", fifo_count);
    end
    power_on_rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, timeout_err, valid, fifo_count, rsp_rank} !== {1'b1, 9'd0}) begin
      failures++;
      $display("FAIL midread_reset_ctrl got=%b exp=%b", {req_ready, rsp_valid, timeout_err, valid, fifo_count, rsp_rank}, {1'b1, 9'd0});
    end
    checks++;
    if ({command, write_data, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL midread_reset_data got cmd=%h wd=%h exp=0", command, write_data);
    end
    step();
    step();
    power_on_rst_n = 1'b1;
    read_data_valid = 1'b1;
    read_data = rand_wd();
    step();
    read_data_valid = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < RD_TIMEOUT + 8; k++) begin
      if (rsp_valid !== 1'b0 || timeout_err !== 1'b0 || valid !== 1'b0 || fifo_count !== 4'd0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_quiet got activity after reset exp=none");
    end
  endtask

  task automatic test_single_write();
    logic [33:0]   w1;
    logic [33:0]   w2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [33:0]   seen_c;
    logic [DW-1:0] seen_d;
    int first;
    int npulse;
    w1 = {2'b10, 1'b0, 31'h155};
    d1 = {4{32'hA5A5A5A5}};
    w2 = mk_cmd(2'd0, 1'b0);
    d2 = rand_wd();
    seen_c = '0;
    seen_d = '0;
    req_valid = 1'b1;
    req_cmd   = w1;
    req_wdata = d1;
    step();
    checks++;
    if (fifo_count !== 4'd1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_latency_t1 got count=%0d valid=%b exp count=1 valid=0", fifo_count, valid);
    end
    req_cmd   = w2;
    req_wdata = d2;
    step();
    req_valid = 1'b0;
    checks++;
    if (valid !== 1'b1 || command !== w1 || write_data !== d1 || fifo_count !== 4'd2) begin
      failures++;
      $display("FAIL wr_issue_t2 got valid=%b cmd=%h wd=%h cnt=%0d exp valid=1 cmd=%h wd=%h cnt=2", valid, command, write_data, fifo_count, w1, d1);
    end
    first  = -1;
    npulse = 0;
    for (int n = 1; n <= WR_GAP + 4; n++) begin
      step();
      if (valid === 1'b1) begin
        npulse++;
        if (first < 0) begin
          first  = n;
          seen_c = command;
          seen_d = write_data;
        end
      end
    end
    checks++;
    if (first != WR_GAP + 2 || npulse != 1) begin
      failures++;
      $display("FAIL wr_gap got offset=%0d pulses=%0d exp offset=%0d pulses=1", first, npulse, WR_GAP + 2);
    end
    checks++;
    if (seen_c !== w2 || seen_d !== d2) begin
      failures++;
      $display("FAIL wr_second got cmd=%h exp cmd=%h", seen_c, w2);
    end
    repeat (WR_GAP + 2) step();
  endtask

  task automatic test_single_read();
    logic [33:0] rc;
    bit ok;
    bit bad;
    rc = {2'b01, 1'b1, 31'h0ABCDE};
    rsp_ready = 1'b0;
    push(rc, rand_wd());
    wait_valid(4, ok);
    checks++;
    if (!ok || command !== rc) begin
      failures++;
      $display("FAIL rd_issue got valid=%b cmd=%h exp valid=1 cmd=%h", valid, command, rc);
    end
    bad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (valid !== 1'b0 || command !== rc || command[33:32] !== 2'b01 || rsp_valid !== 1'b0) bad = 1'b1;
      if (k == 10) begin
        read_data_valid = 1'b1;
        read_data       = 128'h1234;
      end
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rd_cmd_hold got cmd=%h exp=%h held with no valid/rsp", command, rc);
    end
    step();
    read_data_valid = 1'b0;
    read_data       = rand_wd();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 128'h1234 || rsp_rank !== 2'd1) begin
      failures++;
      $display("FAIL rd_rsp got v=%b d=%h rank=%0d exp v=1 d=1234 rank=1", rsp_valid, rsp_rdata, rsp_rank);
    end
    bad = 1'b0;
    repeat (4) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 128'h1234 || rsp_rank !== 2'd1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rd_rsp_hold got v=%b d=%h exp stable 1/1234", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_rsp_clear got=%b exp=0", rsp_valid);
    end
    repeat (2) step();
  endtask

  task automatic test_full_fifo();
    logic [33:0]   cq [9];
    logic [DW-1:0] dq [9];
    logic [DW-1:0] da;
    logic [DW-1:0] dr;
    bit ok;
    int acc;
    rsp_ready = 1'b0;
    da = rand_wd();
    push(mk_cmd(2'd2, 1'b1), rand_wd());
    wait_valid(4, ok);
    step();
    read_data_valid = 1'b1;
    read_data       = da;
    step();
    read_data_valid = 1'b0;
    checks++;
    if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== da) begin
      failures++;
      $display("FAIL full_setup got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_rdata, da);
    end
    for (int i = 0; i < 9; i++) begin
      cq[i] = mk_cmd(2'($urandom_range(0, 3)), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      dq[i] = rand_wd();
    end
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1;
      req_cmd   = cq[acc];
      req_wdata = dq[acc];
      if (req_ready === 1'b1) acc++;
      step();
    end
    checks++;
    if (acc != 8 || req_ready !== 1'b0 || fifo_count !== 4'd8 || valid !== 1'b0) begin
      failures++;
      $display("FAIL full_fill got acc=%0d rdy=%b cnt=%0d exp acc=8 rdy=0 cnt=8", acc, req_ready, fifo_count);
    end
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== da) begin
      failures++;
      $display("FAIL full_rsp_hold got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_rdata, da);
    end
    rsp_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      wait_valid(20, ok);
      checks++;
      if (!ok || command !== cq[i] || write_data !== dq[i]) begin
        failures++;
        $display("FAIL drain_order[%0d] got cmd=%h exp cmd=%h", i, command, cq[i]);
      end
      step();
      if (cq[i][31]) begin
        dr = rand_wd();
        read_data_valid = 1'b1;
        read_data       = dr;
        step();
        read_data_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== dr || rsp_rank !== cq[i][33:32]) begin
          failures++;
          $display("FAIL drain_rsp[%0d] got v=%b d=%h r=%0d exp d=%h r=%0d", i, rsp_valid, rsp_rdata, rsp_rank, dr, cq[i][33:32]);
        end
        step();
      end
    end
    repeat (WR_GAP + 3) step();
    rsp_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty got cnt=%0d rdy=%b exp cnt=0 rdy=1", fifo_count, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0]   r1;
    logic [33:0]   r2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    bit ok;
    bit bad;
    r1 = mk_cmd(2'd3, 1'b1);
    r2 = mk_cmd(2'd0, 1'b1);
    d1 = rand_wd();
    d2 = rand_wd();
    rsp_ready = 1'b0;
    push(r1, rand_wd());
    push(r2, rand_wd());
    wait_valid(4, ok);
    checks++;
    if (!ok || command !== r1) begin
      failures++;
      $display("FAIL bp_first got cmd=%h exp=%h", command, r1);
    end
    step();
    read_data_valid = 1'b1;
    read_data       = d1;
    step();
    read_data_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== d1 || rsp_rank !== 2'd3) begin
      failures++;
      $display("FAIL bp_rsp1 got v=%b d=%h r=%0d exp v=1 d=%h r=3", rsp_valid, rsp_rdata, rsp_rank, d1);
    end
    bad = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (valid !== 1'b0) bad = 1'b1;
      if (k == 6 && rsp_valid !== 1'b0) bad = 1'b1;
      rsp_ready = (k == 5);
      step();
    end
    rsp_ready = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold got early issue or rsp not cleared exp issue only after handshake");
    end
    checks++;
    if (valid !== 1'b1 || command !== r2) begin
      failures++;
      $display("FAIL bp_second got valid=%b cmd=%h exp valid=1 cmd=%h", valid, command, r2);
    end
    step();
    read_data_valid = 1'b1;
    read_data       = d2;
    step();
    read_data_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== d2 || rsp_rank !== 2'd0) begin
      failures++;
      $display("FAIL bp_rsp2 got v=%b d=%h r=%0d exp d=%h r=0", rsp_valid, rsp_rdata, rsp_rank, d2);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    logic [33:0]   rc;
    logic [33:0]   wc;
    logic [DW-1:0] wd;
    bit ok;
    bit bad;
    rc = mk_cmd(2'd3, 1'b1);
    wc = mk_cmd(2'd1, 1'b0);
    wd = rand_wd();
    rsp_ready = 1'b0;
    push(rc, rand_wd());
    push(wc, wd);
    wait_valid(4, ok);
    checks++;
    if (!ok || command !== rc) begin
      failures++;
      $display("FAIL to_issue got cmd=%h exp=%h", command, rc);
    end
    bad = 1'b0;
    for (int k = 1; k <= RD_TIMEOUT; k++) begin
      step();
      if (timeout_err !== 1'b0 || valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL to_early got early timeout_err or issue exp none before %0d", RD_TIMEOUT + 1);
    end
    step();
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_pulse got=%b exp=1", timeout_err);
    end
    read_data_valid = 1'b1;
    read_data       = rand_wd();
    step();
    read_data_valid = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || valid !== 1'b1 || command !== wc || write_data !== wd || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_after got to=%b v=%b cmd=%h rsp=%b exp to=0 v=1 cmd=%h rsp=0", timeout_err, valid, command, rsp_valid, wc);
    end
    bad = 1'b0;
    repeat (WR_GAP + 3) begin
      step();
      if (rsp_valid !== 1'b0 || timeout_err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL to_no_rsp got rsp_valid or extra timeout_err exp none");
    end
  endtask

  task automatic test_random_traffic();
    localparam int N = 40;
    fork
      begin : producer
        req_t r;
        int g;
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 3)) step();
          r.cmd = mk_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          r.wd  = rand_wd();
          req_valid = 1'b1;
          req_cmd   = r.cmd;
          req_wdata = r.wd;
          g = 0;
          while (req_ready !== 1'b1 && g < 2000) begin
            step();
            g++;
          end
          if (req_ready === 1'b1) begin
            model_q.push_back(r);
            step();
            req_valid = 1'b0;
          end else begin
            req_valid = 1'b0;
            checks++;
            failures++;
            $display("FAIL rnd_accept got req_ready stuck low exp accept");
            break;
          end
        end
      end
      begin : consumer
        req_t e;
        int issued, last_v, rd_due, guard;
        bit last_w, pend, pend_prev, pend_next;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_rank;
        logic [1:0]    cur_rank;
        issued = 0; last_v = -1000; rd_due = -1; guard = 0;
        last_w = 1'b0; pend = 1'b0; pend_prev = 1'b0;
        exp_d = '0; exp_rank = '0; cur_rank = '0;
        while ((issued < N || rd_due >= 0 || pend) && guard < 5000) begin
          checks++;
          if (rsp_valid !== pend || (pend && (rsp_rdata !== exp_d || rsp_rank !== exp_rank))) begin
            failures++;
            $display("FAIL rnd_rsp got v=%b d=%h r=%0d exp v=%b d=%h r=%0d", rsp_valid, rsp_rdata, rsp_rank, pend, exp_d, exp_rank);
          end
          if (valid === 1'b1) begin
            checks++;
            if (model_q.size() == 0) begin
              failures++;
              $display("FAIL rnd_unexpected got issue cmd=%h exp none", command);
            end else begin
              e = model_q.pop_front();
              if (command !== e.cmd || write_data !== e.wd) begin
                failures++;
                $display("FAIL rnd_order got cmd=%h exp cmd=%h", command, e.cmd);
              end
              if (last_w && (cyc - last_v) < WR_GAP + 2) begin
                failures++;
                $display("FAIL rnd_wr_gap got=%0d exp>=%0d", cyc - last_v, WR_GAP + 2);
              end
              if (rd_due >= 0 || (e.cmd[31] && pend_prev)) begin
                failures++;
                $display("FAIL rnd_rd_busy got issue while read outstanding or response pending exp hold");
              end
              if (e.cmd[31]) begin
                rd_due   = cyc + $urandom_range(1, 12);
                cur_rank = e.cmd[33:32];
              end
              last_v = cyc;
              last_w = !e.cmd[31];
              issued++;
            end
          end
          read_data_valid = 1'b0;
          read_data       = rand_wd();
          rsp_ready       = ($urandom_range(0, 3) == 0);
          pend_next       = pend;
          if (rd_due >= 0 && rd_due == cyc) begin
            read_data_valid = 1'b1;
            exp_d     = read_data;
            exp_rank  = cur_rank;
            pend_next = 1'b1;
            rd_due    = -1;
          end else if (pend && rsp_ready) begin
            pend_next = 1'b0;
          end
          pend_prev = pend;
          pend      = pend_next;
          step();
          guard++;
        end
        read_data_valid = 1'b0;
        rsp_ready       = 1'b0;
        checks++;
        if (guard >= 5000 || model_q.size() != 0) begin
          failures++;
          $display("FAIL rnd_complete got issued=%0d left=%0d exp issued=%0d left=0", issued, model_q.size(), N);
        end
      end
    join
  endtask

  initial begin
    power_on_rst_n  = 1'b0;
    req_valid       = 1'b0;
    req_cmd         = '0;
    req_wdata       = '0;
    rsp_ready       = 1'b0;
    read_data       = '0;
    read_data_valid = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_full_fifo();
    test_back_to_back();
    test_timeout();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
